turn_arbiter: RTL and testbench
===============================

# turn_arbiter

Turn-based scheduler between the two players' debounced button pulses and the shared shot-resolution logic of the battleship game. It admits a fire request only from the player whose turn it is and latches that player's target coordinate. It issues the shot over a valid/ready handshake, waits for the hit/miss result, then decides who fires next. It also applies a per-turn timeout and reports the winner.

## Interface
- COORD_W, 4, width of target coordinate (row/column packed)
- TIMEOUT_CYC, 1000, cycles a player may wait in WAIT_FIRE before the turn is skipped; 0 disables the timeout
- EXTRA_SHOT_ON_HIT, 1, 1 = a hit keeps the turn with the shooter; 0 = the turn always alternates

- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- start_pulse  in  1  single-cycle debounced start/restart pulse
- fire_a, fire_b  in  1  single-cycle debounced fire pulses, player A / player B
- coord_a, coord_b  in  COORD_W  target switches, sampled with the fire pulse
- shot_valid  out  1  shot request to the resolution logic
- shot_ready  in  1  resolution logic accepts the shot
- shot_player  out  1  shooter, 0 = A, 1 = B; stable while shot_valid is high
- shot_coord  out  COORD_W  latched target; stable while shot_valid is high
- result_valid  in  1  single-cycle result strobe
- result_hit  in  1  1 = hit; qualified by result_valid
- game_over  in  1  last ship sunk; qualified by result_valid
- turn  out  1  player allowed to fire, 0 = A
- busy  out  1  high in all states except IDLE and DONE
- illegal_a, illegal_b  out  1  one-cycle pulse for a rejected fire
- skip_pulse  out  1  one-cycle pulse when a turn times out
- winner_valid  out  1  high in DONE
- winner  out  1  winning player; valid while winner_valid is high
- shot_count  out  8  shots issued this game, saturates at 255

## Operation
- States: IDLE, WAIT_FIRE, ISSUE, WAIT_RESULT, DONE.
- IDLE
  - start_pulse -> WAIT_FIRE; turn = A, timer = 0, shot_count = 0.
- WAIT_FIRE, fire from the current turn player
  - Latch that player's coord into shot_coord and turn into shot_player.
  - Go to ISSUE.
- WAIT_FIRE, fire from the other player
  - Pulse illegal_x; the fire is otherwise ignored.
  - If fire_a and fire_b arrive in the same cycle, the current player's fire is accepted and the other pulses illegal.
- WAIT_FIRE, timer (TIMEOUT_CYC != 0)
  - The timer increments every cycle.
  - When the timer == TIMEOUT_CYC-1 and no acceptable fire is present that cycle: pulse skip_pulse, toggle turn, clear the timer, stay in WAIT_FIRE.
  - An acceptable fire in the timeout cycle wins; no skip occurs.
- ISSUE
  - shot_valid is high and shot_player/shot_coord are held.
  - When shot_valid & shot_ready at a clock edge: go to WAIT_RESULT and increment shot_count (saturating).
  - Any fire pulse in ISSUE or WAIT_RESULT pulses illegal_x for its player.
- WAIT_RESULT, on result_valid
  - If game_over: go to DONE with winner = shot_player. game_over overrides result_hit.
  - Else if result_hit & EXTRA_SHOT_ON_HIT: turn unchanged. Otherwise toggle turn.
  - In both non-game_over cases: return to WAIT_FIRE with timer = 0.
  - result_valid is ignored outside WAIT_RESULT.
- DONE
  - winner_valid is high.
  - start_pulse -> WAIT_FIRE with a fresh game (turn = A, shot_count = 0, winner_valid = 0).
- start_pulse is ignored in WAIT_FIRE, ISSUE and WAIT_RESULT.
- Fire pulses in IDLE and DONE are ignored and raise no illegal pulse.
- Reset asserted in any state: all state clears immediately to IDLE, including any in-flight shot handshake.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE
  - shot_valid = 0, shot_player = 0, shot_coord = 0
  - turn = 0, busy = 0
  - illegal_a = 0, illegal_b = 0, skip_pulse = 0
  - winner_valid = 0, winner = 0
  - shot_count = 0, timer = 0
- Latencies:
  - start_pulse at edge N -> busy = 1 after edge N.
  - Fire accepted at edge N -> shot_valid = 1 after edge N (one-cycle latency).
  - Handshake at edge M -> shot_valid = 0 after edge M; a result strobe in cycle M is not honoured.
  - result_valid at edge K -> new turn visible and WAIT_FIRE entered after edge K.
  - illegal_x and skip_pulse are high for exactly one cycle after the triggering edge.
- Timer width is $clog2(TIMEOUT_CYC+1); it never exceeds TIMEOUT_CYC-1.

## Test plan
- Reset, then start_pulse, then fire_a with coord_a = 4'h9, shot_ready tied high.
  - Required: shot_valid high for one cycle with shot_player = 0, shot_coord = 9; shot_count = 1.
- shot_ready low for 5 cycles after the request, then high.
  - Required: shot_valid stays high and coord stays constant for 6 cycles; one transfer only.
- fire_b during A's turn, then fire_a and fire_b in the same cycle.
  - Required: illegal_b pulses twice; only A's shot is issued.
- Miss result with EXTRA_SHOT_ON_HIT = 1 -> turn = 1. Hit result -> turn unchanged.
- TIMEOUT_CYC = 8 with no fire.
  - Required: skip_pulse 8 cycles after WAIT_FIRE entry; turn toggles.
  - Repeat with fire_a in the 8th cycle: shot issued, no skip.
- Result strobe with game_over = 1 and result_hit = 1 from player B.
  - Required: DONE, winner_valid = 1, winner = 1.
  - Then start_pulse -> turn = 0, shot_count = 0.
  - Reset asserted mid-ISSUE -> shot_valid = 0 immediately.

Source files
------------

// File: rtl/turn_arbiter.sv
// +--------------------------------------------------------------------------+
// | turn_arbiter : turn scheduler between two players and shot resolution    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module turn_arbiter #(
  parameter int COORD_W           = 4,
  parameter int TIMEOUT_CYC       = 1000,
  parameter int EXTRA_SHOT_ON_HIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_pulse,
  input  logic               fire_a,
  input  logic               fire_b,
  input  logic [COORD_W-1:0] coord_a,
  input  logic [COORD_W-1:0] coord_b,
  output logic               shot_valid,
  input  logic               shot_ready,
  output logic               shot_player,
  output logic [COORD_W-1:0] shot_coord,
  input  logic               result_valid,
  input  logic               result_hit,
  input  logic               game_over,
  output logic               turn,
  output logic               busy,
  output logic               illegal_a,
  output logic               illegal_b,
  output logic               skip_pulse,
  output logic               winner_valid,
  output logic               winner,
  output logic [7:0]         shot_count
);

  localparam int TIMER_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST =
      TIMER_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);
  localparam bit KEEP_ON_HIT = (EXTRA_SHOT_ON_HIT != 0);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_FIRE   = 3'd1,
    ISSUE       = 3'd2,
    WAIT_RESULT = 3'd3,
    DONE        = 3'd4
  } state_t;

  state_t               state;
  logic [TIMER_W-1:0]   timer;

  logic fire_cur;
  logic timeout_hit;

  assign fire_cur    = turn ? fire_b : fire_a;
  assign timeout_hit = TIMEOUT_EN && (timer == TIMER_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      timer        <= '0;
      shot_valid   <= 1'b0;
      shot_player  <= 1'b0;
      shot_coord   <= '0;
      turn         <= 1'b0;
      busy         <= 1'b0;
      illegal_a    <= 1'b0;
      illegal_b    <= 1'b0;
      skip_pulse   <= 1'b0;
      winner_valid <= 1'b0;
      winner       <= 1'b0;
      shot_count   <= 8'd0;
    end else begin
      illegal_a  <= 1'b0;
      illegal_b  <= 1'b0;
      skip_pulse <= 1'b0;

      case (state)
        IDLE, DONE: begin
          // Fire pulses outside a game are silently dropped.
          if (start_pulse) begin
            state        <= WAIT_FIRE;
            turn         <= 1'b0;
            timer        <= '0;
            shot_count   <= 8'd0;
            busy         <= 1'b1;
            winner_valid <= 1'b0;
          end
        end

        WAIT_FIRE: begin
          illegal_a <= fire_a & turn;
          illegal_b <= fire_b & ~turn;
          if (fire_cur) begin
            shot_player <= turn;
            shot_coord  <= turn ? coord_b : coord_a;
            shot_valid  <= 1'b1;
            state       <= ISSUE;
          end else if (timeout_hit) begin
            skip_pulse <= 1'b1;
            turn       <= ~turn;
            timer      <= '0;
          end else if (TIMEOUT_EN) begin
            timer <= timer + 1'b1;
          end
        end

        ISSUE: begin
          illegal_a <= fire_a;
          illegal_b <= fire_b;
          if (shot_ready) begin
            shot_valid <= 1'b0;
            state      <= WAIT_RESULT;
            if (shot_count != 8'hFF) begin
              shot_count <= shot_count + 8'd1;
            end
          end
        end

        WAIT_RESULT: begin
          illegal_a <= fire_a;
          illegal_b <= fire_b;
          if (result_valid) begin
            if (game_over) begin
              state        <= DONE;
              winner       <= shot_player;
              winner_valid <= 1'b1;
              busy         <= 1'b0;
            end else begin
              if (!(result_hit && KEEP_ON_HIT)) begin
                turn <= ~turn;
              end
              timer <= '0;
              state <= WAIT_FIRE;
            end
          end
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          shot_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_turn_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_turn_arbiter : scoreboard bench with a behavioural game model         |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_turn_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_pulse = 1'b0, fire_a = 1'b0, fire_b = 1'b0;
  logic [3:0] coord_a = 4'h0, coord_b = 4'h0;
  logic       shot_ready = 1'b0, result_valid = 1'b0, result_hit = 1'b0, game_over = 1'b0;
  logic       shot_valid, shot_player, turn, busy, illegal_a, illegal_b;
  logic       skip_pulse, winner_valid, winner;
  logic [3:0] shot_coord;
  logic [7:0] shot_count;

  turn_arbiter #(.COORD_W(4), .TIMEOUT_CYC(TO), .EXTRA_SHOT_ON_HIT(1)) dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse),
    .fire_a(fire_a), .fire_b(fire_b), .coord_a(coord_a), .coord_b(coord_b),
    .shot_valid(shot_valid), .shot_ready(shot_ready), .shot_player(shot_player),
    .shot_coord(shot_coord), .result_valid(result_valid), .result_hit(result_hit),
    .game_over(game_over), .turn(turn), .busy(busy), .illegal_a(illegal_a),
    .illegal_b(illegal_b), .skip_pulse(skip_pulse), .winner_valid(winner_valid),
    .winner(winner), .shot_count(shot_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit trn, bsy, sv, wv, win, ia, ib, sk;
    int cnt;
  } status_t;

  typedef struct {
    bit         p;
    logic [3:0] c;
  } shot_t;

  status_t status_q[$];
  shot_t   shot_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: game phases as named by the rules, counted in whole cycles
  localparam int P_IDLE = 0, P_FIRE = 1, P_OFFER = 2, P_RESULT = 3, P_DONE = 4;
  int phase = P_IDLE;
  int waited = 0;
  int shots = 0;
  bit turn_m = 0, win_m = 0, last_shooter = 0;

  always @(posedge clk) begin
    status_t s;
    bit acc, oth;
    s.ia = 0; s.ib = 0; s.sk = 0;
    if (!rst) begin
      phase = P_IDLE; waited = 0; shots = 0; turn_m = 0; win_m = 0;
    end else begin
      case (phase)
        P_IDLE, P_DONE: if (start_pulse) begin
          phase = P_FIRE; turn_m = 0; shots = 0; waited = 0;
        end
        P_FIRE: begin
          acc = turn_m ? fire_b : fire_a;
          oth = turn_m ? fire_a : fire_b;
          if (oth) begin
            if (turn_m) s.ia = 1; else s.ib = 1;
          end
          if (acc) begin
            last_shooter = turn_m;
            shot_q.push_back('{turn_m, turn_m ? coord_b : coord_a});
            phase = P_OFFER;
          end else begin
            waited++;
            if (waited == TO) begin
              s.sk = 1; turn_m = ~turn_m; waited = 0;
            end
          end
        end
        P_OFFER: begin
          s.ia = fire_a; s.ib = fire_b;
          if (shot_ready) begin
            shots = (shots < 255) ? shots + 1 : 255;
            phase = P_RESULT;
          end
        end
        P_RESULT: begin
          s.ia = fire_a; s.ib = fire_b;
          if (result_valid) begin
            if (game_over) begin
              phase = P_DONE; win_m = last_shooter;
            end else begin
              if (!result_hit) turn_m = ~turn_m;
              waited = 0;
              phase = P_FIRE;
            end
          end
        end
        default: phase = P_IDLE;
      endcase
    end
    s.trn = turn_m;
    s.bsy = (phase == P_FIRE) || (phase == P_OFFER) || (phase == P_RESULT);
    s.sv  = (phase == P_OFFER);
    s.wv  = (phase == P_DONE);
    s.win = win_m;
    s.cnt = shots;
    status_q.push_back(s);
  end

  // Monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    status_t e;
    if (status_q.size() > 0) begin
      e = status_q.pop_front();
      chk("turn", turn, e.trn);
      chk("busy", busy, e.bsy);
      chk("shot_valid", shot_valid, e.sv);
      chk("winner_valid", winner_valid, e.wv);
      if (e.wv) chk("winner", winner, e.win);
      chk("shot_count", shot_count, e.cnt);
      chk("illegal_a", illegal_a, e.ia);
      chk("illegal_b", illegal_b, e.ib);
      chk("skip_pulse", skip_pulse, e.sk);
    end
    if (shot_valid === 1'b1) begin
      if (shot_q.size() == 0) begin
        chk("shot_pending", shot_q.size(), 1);
      end else begin
        chk("shot_player", shot_player, shot_q[0].p);
        chk("shot_coord", shot_coord, shot_q[0].c);
        if (shot_ready) void'(shot_q.pop_front());
      end
    end
  end

  task automatic step_in(input bit st, input bit fa, input bit fb,
                         input logic [3:0] ca, input logic [3:0] cb,
                         input bit rdy, input bit rv, input bit hit, input bit go);
    start_pulse = st; fire_a = fa; fire_b = fb; coord_a = ca; coord_b = cb;
    shot_ready = rdy; result_valid = rv; result_hit = hit; game_over = go;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step_in(0, 0, 0, 4'h0, 4'h0, rdy, 0, 0, 0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_shot_valid", shot_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    shot_q.delete();
    start_pulse = 0; fire_a = 0; fire_b = 0; shot_ready = 0;
    result_valid = 0; result_hit = 0; game_over = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_shot_coord", shot_coord, 4'h0);
    chk("reset_shot_player", shot_player, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;

    // A fires at 9 with ready high, then misses
    step_in(1, 0, 0, 4'h0, 4'h0, 1, 0, 0, 0);
    step_in(0, 1, 0, 4'h9, 4'h0, 1, 0, 0, 0);
    step_in(0, 0, 0, 4'h0, 4'h0, 1, 0, 0, 0);
    step_in(0, 0, 0, 4'h0, 4'h0, 0, 1, 0, 0);
    // B fires at 3 with a stalled ready, hits and keeps the turn
    step_in(0, 0, 1, 4'h0, 4'h3, 0, 0, 0, 0);
    idle_n(5, 0);
    step_in(0, 0, 0, 4'h0, 4'h0, 1, 0, 0, 0);
    step_in(0, 0, 0, 4'h0, 4'h0, 0, 1, 1, 0);
    // B fires again, misses: back to A
    step_in(0, 0, 1, 4'h0, 4'h5, 1, 0, 0, 0);
    step_in(0, 0, 0, 4'h0, 4'h0, 1, 0, 0, 0);
    step_in(0, 0, 0, 4'h0, 4'h0, 0, 1, 0, 0);
    // Out-of-turn B, then simultaneous fires
    step_in(0, 0, 1, 4'h0, 4'h7, 0, 0, 0, 0);
    step_in(0, 1, 1, 4'hA, 4'h7, 1, 0, 0, 0);
    step_in(0, 0, 0, 4'h0, 4'h0, 1, 0, 0, 0);
    step_in(0, 0, 0, 4'h0, 4'h0, 0, 1, 0, 0);
    // B times out; A then fires in its timeout cycle
    idle_n(TO, 0);
    idle_n(TO - 1, 0);
    step_in(0, 1, 0, 4'hC, 4'h0, 1, 0, 0, 0);
    step_in(0, 0, 0, 4'h0, 4'h0, 1, 0, 0, 0);
    step_in(0, 0, 0, 4'h0, 4'h0, 0, 1, 0, 0);
    // B sinks the last ship
    step_in(0, 0, 1, 4'h0, 4'h2, 1, 0, 0, 0);
    step_in(0, 0, 0, 4'h0, 4'h0, 1, 0, 0, 0);
    step_in(0, 0, 0, 4'h0, 4'h0, 0, 1, 1, 1);
    step_in(0, 1, 1, 4'h1, 4'h1, 0, 1, 0, 0);
    idle_n(2, 0);
    // Restart, then reset during an outstanding shot
    step_in(1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0);
    step_in(0, 1, 0, 4'h6, 4'h0, 0, 0, 0, 0);
    mid_reset();

    // Randomized play
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) mid_reset();
      step_in($urandom_range(29) == 0,
              $urandom_range(9) == 0, $urandom_range(9) == 0,
              4'($urandom), 4'($urandom),
              $urandom_range(1) == 1, $urandom_range(3) == 0,
              $urandom_range(1) == 1, $urandom_range(9) == 0);
    end
    idle_n(3, 0);
    chk("shot_queue_depth_le1", shot_q.size() <= 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
